batrider_cen_sched: RTL and testbench

BATRIDER_CEN_SCHED -- requirements
Module: batrider_cen_sched

---
 rtl/batrider_cen_sched.sv | 182 ++++++++++++++++++
 tb/tb_batrider_cen_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/batrider_cen_sched.sv
// Four fractional-N clock-enable generators (rate N/M) with a handshaked reconfiguration port.
// Optional macro BATRIDER_CEN_SLOWDOWN_EN adds SLOW[1:0] pulse decimation per channel.
module batrider_cen_sched #(
    parameter logic [63:0] NDEF = {16'd1, 16'd1, 16'd1, 16'd1},
    parameter logic [79:0] MDEF = {20'd7, 20'd18, 20'd30, 20'd24}
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PAUSE,
`ifdef BATRIDER_CEN_SLOWDOWN_EN
    input  logic [1:0]  SLOW,
`endif
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [1:0]  CFG_CH,
    input  logic [15:0] CFG_N,
    input  logic [19:0] CFG_M,
    output logic        CFG_ERR,
    output logic [3:0]  CEN,
    output logic [3:0]  CENB
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_APPLY = 1'b1;

    logic [0:0]  state_r;
    logic        ready_r;
    logic        err_r;
    logic [1:0]  pend_ch_r;
    logic [15:0] pend_n_r;
    logic [19:0] pend_m_r;
    logic        pend_ok_r;

    logic [15:0] n_r   [4];
    logic [19:0] m_r   [4];
    logic [19:0] acc_r [4];
    logic [3:0]  h_r;
    logic [3:0]  cen_r;
    logic [3:0]  cenb_r;

    logic [20:0] sum_s      [4];
    logic [19:0] acc_next_s [4];
    logic [3:0]  hit_s;
    logic [3:0]  half_s;
    logic [3:0]  apply_s;
    logic [3:0]  hide_s;
    logic [3:0]  gate_s;
    logic        accept_s;
    logic        cfg_ok_s;

    // Accumulator step, pulse decisions and configuration decode
    always_comb begin
        cfg_ok_s = (CFG_M != 20'd0) && ({4'd0, CFG_N} <= CFG_M);
        accept_s = CFG_VALID & ready_r;
        hit_s    = 4'd0;
        half_s   = 4'd0;
        apply_s  = 4'd0;
        hide_s   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            sum_s[i]  = {1'b0, acc_r[i]} + {5'd0, n_r[i]};
            hit_s[i]  = (sum_s[i] >= {1'b0, m_r[i]});
            // n==0 must stay silent even when m==1 makes the half-point zero
            half_s[i] = !hit_s[i] && !h_r[i] && (n_r[i] != 16'd0)
                        && (sum_s[i] >= {2'd0, m_r[i][19:1]});
            if (hit_s[i]) begin
                acc_next_s[i] = 20'(sum_s[i] - {1'b0, m_r[i]});
            end else begin
                acc_next_s[i] = sum_s[i][19:0];
            end
            apply_s[i] = (state_r == ST_APPLY) && pend_ok_r && (pend_ch_r == 2'(i));
            hide_s[i]  = accept_s && cfg_ok_s && (CFG_CH == 2'(i));
        end
    end

`ifdef BATRIDER_CEN_SLOWDOWN_EN
    logic [1:0] cnt_r [4];
    logic [1:0] slow_mask_s;

    // Decimation modulus and per-channel pass gate
    always_comb begin
        case (SLOW)
            2'd0:    slow_mask_s = 2'd0;
            2'd1:    slow_mask_s = 2'd1;
            default: slow_mask_s = 2'd3;
        endcase
        gate_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            gate_s[i] = (cnt_r[i] == 2'd0);
        end
    end
`else
    assign gate_s = 4'b1111;
`endif

    // Configuration port handshake; the write is captured on accept and applied one cycle later
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            pend_ch_r <= 2'd0;
            pend_n_r  <= 16'd0;
            pend_m_r  <= 20'd0;
            pend_ok_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_APPLY;
                        ready_r   <= 1'b0;
                        err_r     <= !cfg_ok_s;
                        pend_ch_r <= CFG_CH;
                        pend_n_r  <= CFG_N;
                        pend_m_r  <= CFG_M;
                        pend_ok_r <= cfg_ok_s;
                    end else begin
                        ready_r <= 1'b1;
                        err_r   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state_r   <= ST_IDLE;
                    ready_r   <= 1'b1;
                    err_r     <= 1'b0;
                    pend_ok_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    ready_r   <= 1'b0;
                    err_r     <= 1'b0;
                    pend_ok_r <= 1'b0;
                end
            endcase
        end
    end

    // Channel state: reset defaults, reconfiguration, pause hold, normal accumulation
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (RESET) begin
                n_r[i]    <= NDEF[i*16 +: 16];
                m_r[i]    <= MDEF[i*20 +: 20];
                acc_r[i]  <= 20'd0;
                h_r[i]    <= 1'b0;
                cen_r[i]  <= 1'b0;
                cenb_r[i] <= 1'b0;
`ifdef BATRIDER_CEN_SLOWDOWN_EN
                cnt_r[i]  <= 2'd0;
`endif
            end else if (apply_s[i]) begin
                n_r[i]    <= pend_n_r;
                m_r[i]    <= pend_m_r;
                acc_r[i]  <= 20'd0;
                h_r[i]    <= 1'b0;
                cen_r[i]  <= 1'b0;
                cenb_r[i] <= 1'b0;
            end else if (PAUSE) begin
                cen_r[i]  <= 1'b0;
                cenb_r[i] <= 1'b0;
            end else begin
                acc_r[i]  <= acc_next_s[i];
                h_r[i]    <= hit_s[i] ? 1'b0 : (half_s[i] | h_r[i]);
                // a channel about to be rewritten stays silent while the write is in flight
                cen_r[i]  <= hit_s[i] & gate_s[i] & !hide_s[i];
                cenb_r[i] <= half_s[i] & gate_s[i] & !hide_s[i];
`ifdef BATRIDER_CEN_SLOWDOWN_EN
                if (hit_s[i]) begin
                    cnt_r[i] <= (cnt_r[i] + 2'd1) & slow_mask_s;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
`endif
            end
        end
    end

    assign CFG_READY = ready_r;
    assign CFG_ERR   = err_r;
    assign CEN       = cen_r;
    assign CENB      = cenb_r;

endmodule

// File: tb/tb_batrider_cen_sched.sv
// Directed self-checking bench for batrider_cen_sched; expected values are hand-derived from N/M.
module tb_batrider_cen_sched;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PAUSE = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic [1:0]  CFG_CH = 2'd0;
    logic [15:0] CFG_N = 16'd0;
    logic [19:0] CFG_M = 20'd0;
    logic        CFG_READY;
    logic        CFG_ERR;
    logic [3:0]  CEN;
    logic [3:0]  CENB;
`ifdef BATRIDER_CEN_SLOWDOWN_EN
    logic [1:0]  SLOW = 2'd0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    batrider_cen_sched dut (
        .CLK(CLK), .RESET(RESET), .PAUSE(PAUSE),
`ifdef BATRIDER_CEN_SLOWDOWN_EN
        .SLOW(SLOW),
`endif
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_CH(CFG_CH),
        .CFG_N(CFG_N), .CFG_M(CFG_M), .CFG_ERR(CFG_ERR),
        .CEN(CEN), .CENB(CENB)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        PAUSE = 1'b0;
        CFG_VALID = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] n, input logic [19:0] m);
        CFG_VALID = 1'b1;
        CFG_CH = ch;
        CFG_N = n;
        CFG_M = m;
        tick();
        CFG_VALID = 1'b0;
        tick();
    endtask

    // ticks until CEN[ch] is seen; -1 when the budget runs out
    task automatic wait_cen(input int ch, input int limit, output int w);
        w = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (CEN[ch]) begin
                w = k;
                break;
            end
        end
    endtask

    initial begin
        int c_cen[4];
        int c_cenb[4];
        int both;
        int pulses;
        int w;

        // reset defaults and free-running rates
        do_reset();
        check_eq("rst_cen", 32'(CEN), 32'd0);
        check_eq("rst_cenb", 32'(CENB), 32'd0);
        check_eq("rst_err", 32'(CFG_ERR), 32'd0);
        check_eq("rst_ready", 32'(CFG_READY), 32'd0);
        for (int c = 0; c < 4; c++) begin
            c_cen[c] = 0;
            c_cenb[c] = 0;
        end
        both = 0;
        for (int k = 0; k < 2400; k++) begin
            tick();
            if (k == 0) check_eq("ready_after_reset", 32'(CFG_READY), 32'd1);
            for (int c = 0; c < 4; c++) begin
                c_cen[c] += int'(CEN[c]);
                c_cenb[c] += int'(CENB[c]);
            end
            both += $countones(CEN & CENB);
        end
        check_eq("cen0_2400", c_cen[0], 32'd100);
        check_eq("cen1_2400", c_cen[1], 32'd80);
        check_eq("cen2_2400", c_cen[2], 32'd133);
        check_eq("cen3_2400", c_cen[3], 32'd342);
        for (int c = 0; c < 4; c++) begin
            check_eq("cenb_near_cen", 32'((c_cenb[c] - c_cen[c] <= 1) && (c_cen[c] - c_cenb[c] <= 1)), 32'd1);
        end
        check_eq("cen_cenb_overlap", both, 32'd0);

        // pause at acc=11 on channel 0
        do_reset();
        repeat (11) tick();
        PAUSE = 1'b1;
        pulses = 0;
        repeat (50) begin
            tick();
            pulses += $countones(CEN) + $countones(CENB);
        end
        check_eq("pause_silent", pulses, 32'd0);
        PAUSE = 1'b0;
        wait_cen(0, 40, w);
        check_eq("pause_resume_gap", w, 32'd13);
        wait_cen(0, 40, w);
        check_eq("pause_next_period", w, 32'd24);

        // invalid writes with CFG_VALID held high
        do_reset();
        tick();
        CFG_VALID = 1'b1;
        CFG_CH = 2'd0;
        CFG_N = 16'd5;
        CFG_M = 20'd3;
        tick();
        check_eq("err1_pulse", 32'(CFG_ERR), 32'd1);
        check_eq("err1_ready_low", 32'(CFG_READY), 32'd0);
        CFG_N = 16'd1;
        CFG_M = 20'd0;
        tick();
        check_eq("err1_clear", 32'(CFG_ERR), 32'd0);
        check_eq("ready_back", 32'(CFG_READY), 32'd1);
        tick();
        check_eq("err2_pulse", 32'(CFG_ERR), 32'd1);
        check_eq("err2_ready_low", 32'(CFG_READY), 32'd0);
        CFG_VALID = 1'b0;
        tick();
        check_eq("err2_clear", 32'(CFG_ERR), 32'd0);
        wait_cen(0, 40, w);
        check_eq("err_phase_kept", w, 32'd19);
        wait_cen(0, 40, w);
        check_eq("err_period_kept", w, 32'd24);

        // reconfigure ch2 to 8/189
        do_reset();
        tick();
        CFG_VALID = 1'b1;
        CFG_CH = 2'd2;
        CFG_N = 16'd8;
        CFG_M = 20'd189;
        tick();
        check_eq("apply_ready_low", 32'(CFG_READY), 32'd0);
        check_eq("apply_cycle_quiet", 32'(CEN[2] | CENB[2]), 32'd0);
        CFG_VALID = 1'b0;
        tick();
        check_eq("post_apply_quiet", 32'(CEN[2] | CENB[2]), 32'd0);
        check_eq("valid_no_err", 32'(CFG_ERR), 32'd0);
        for (int c = 0; c < 4; c++) c_cen[c] = 0;
        repeat (18900) begin
            tick();
            for (int c = 0; c < 4; c++) c_cen[c] += int'(CEN[c]);
        end
        check_eq("ch2_8_189", c_cen[2], 32'd800);
        check_eq("ch0_ref", c_cen[0], 32'd787);
        check_eq("ch1_ref", c_cen[1], 32'd630);
        check_eq("ch3_ref", c_cen[3], 32'd2700);

        // n==m and reset during APPLY
        cfg_write(2'd3, 16'd1000, 20'd1000);
        c_cen[3] = 0;
        c_cenb[3] = 0;
        repeat (20) begin
            tick();
            c_cen[3] += int'(CEN[3]);
            c_cenb[3] += int'(CENB[3]);
        end
        check_eq("full_rate_cen", c_cen[3], 32'd20);
        check_eq("full_rate_cenb", c_cenb[3], 32'd0);
        CFG_VALID = 1'b1;
        CFG_CH = 2'd3;
        CFG_N = 16'd2;
        CFG_M = 20'd5;
        tick();
        CFG_VALID = 1'b0;
        RESET = 1'b1;
        tick();
        check_eq("rst_apply_err", 32'(CFG_ERR), 32'd0);
        check_eq("rst_apply_ready", 32'(CFG_READY), 32'd0);
        check_eq("rst_apply_cen", 32'(CEN), 32'd0);
        RESET = 1'b0;
        wait_cen(3, 20, w);
        check_eq("rst_apply_first", w, 32'd7);
        wait_cen(3, 20, w);
        check_eq("rst_apply_period", w, 32'd7);

        // write while paused, then a silent n==0 channel
        do_reset();
        PAUSE = 1'b1;
        tick();
        cfg_write(2'd0, 16'd1, 20'd10);
        pulses = 0;
        repeat (10) begin
            tick();
            pulses += int'(CEN[0]);
        end
        check_eq("paused_write_frozen", pulses, 32'd0);
        PAUSE = 1'b0;
        wait_cen(0, 40, w);
        check_eq("paused_write_resume", w, 32'd10);
        cfg_write(2'd1, 16'd0, 20'd1);
        pulses = 0;
        repeat (30) begin
            tick();
            pulses += int'(CEN[1]) + int'(CENB[1]);
        end
        check_eq("n_zero_silent", pulses, 32'd0);

`ifdef BATRIDER_CEN_SLOWDOWN_EN
        // decimation by 4 on the default channel 0
        SLOW = 2'd2;
        do_reset();
        c_cen[0] = 0;
        repeat (2400) begin
            tick();
            c_cen[0] += int'(CEN[0]);
        end
        check_eq("slow2_cen0", c_cen[0], 32'd25);
        SLOW = 2'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
